score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Upstream stage of the 4-digit seven-segment display driver; produces the 16-bit binary score that driver splits into decimal digits.
- Synchronises and debounces three raw push-buttons (increment, decrement, clear) and converts each into a single-cycle press event.
- Maintains a saturating score in 0..MAX_SCORE and a running high score.

Parameters:
- DEBOUNCE_CNT, 1000000, clocks a synchronised button level must stay stable before it is accepted (10 ms at 100 MHz).
- POINTS, 1, amount added per accepted increment press.
- PENALTY, 1, amount subtracted per accepted decrement press.
- MAX_SCORE, 9999, upper saturation limit; must be no more than 9999 so the display shows at most 4 digits.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_inc  input  1  raw increment button, active high, asynchronous to clk.
- btn_dec  input  1  raw decrement button, active high, asynchronous to clk.
- btn_clr  input  1  raw clear button, active high, asynchronous to clk.
- score  output  16  current score, binary, 0..MAX_SCORE; feeds the display driver.
- high_score  output  16  highest score reached since reset.
- score_changed  output  1  one-cycle pulse when score takes a new value.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: score=0, high_score=0, score_changed=0, all sync flops=0, all debounce counters=0, all debounced levels=0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button, with an independent 32-bit counter:
  - If sync level equals the debounced level, counter=0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CNT-1, the debounced level takes the sync level and the counter returns to 0.
  - Any bounce (sync level returning to the debounced level) before that point resets the counter.
- Press event: one-cycle pulse on a 0->1 transition of the debounced level only. Release produces no event; a held button produces exactly one event.
- Latency: a clean press is first seen at score DEBOUNCE_CNT+3 clocks after the raw edge: 2 sync stages + DEBOUNCE_CNT counting + 1 register.
- Score update, registered, priority order evaluated on the same cycle:
  1. clr event: score <= 0.
  2. inc and dec events together: no change.
  3. inc event: score <= min(score+POINTS, MAX_SCORE); computed 17-bit wide, no wrap.
  4. dec event: score <= (score < PENALTY) ? 0 : score-PENALTY; never underflows.
- score_changed asserts the cycle after the register update, only when the new value differs from the old. It does not assert for:
  - increment at MAX_SCORE
  - decrement at 0
  - clear at 0
- High score:
  - high_score <= score whenever score > high_score, evaluated one cycle after score updates.
  - Clear does not reset high_score; only rst_n does.
- Reset mid-debounce: the counter clears; a button still held at release of reset must be re-qualified for DEBOUNCE_CNT clocks before its press event.
- States per button: IDLE_LOW, QUAL_HIGH (counting), IDLE_HIGH, QUAL_LOW (counting). Transitions are as in the debounce rule above.

Test Plan (DEBOUNCE_CNT=4 in simulation):
- Reset, then three clean btn_inc presses, each held 20 clocks -> score steps 0,1,2,3; three score_changed pulses; high_score=3.
- btn_inc glitching high for 2 clocks then low -> no event; score unchanged; score_changed stays 0.
- Preload score to 9999 via presses with POINTS=1000, then press inc -> score=9999 (not 10999, not wrapped); no score_changed pulse on the final press.
- score=2, PENALTY=5, press dec -> score=0; score_changed pulses once; a further dec press -> score stays 0, no pulse.
- score=7, high_score=7, press clr -> score=0, high_score=7; then two inc presses -> score=2, high_score=7.
- inc and dec debounced to the same cycle -> score unchanged. Separately, assert rst_n low mid-qualification with btn_inc held -> all outputs 0 immediately (asynchronous); after release, an event only after 4+ stable clocks.

Source files
------------

// File: rtl/score_keeper.sv
// Button front end and score register for the 4-digit display driver: three raw buttons are
// synchronised and debounced into single-cycle press events that drive a saturating score and high score.
module score_keeper #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int POINTS       = 1,
    parameter int PENALTY      = 1,
    parameter int MAX_SCORE    = 9999   // at most 9999 so the display never needs a fifth digit
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_clr,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        score_changed
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        QUAL_HIGH,
        IDLE_HIGH,
        QUAL_LOW
    } deb_state_t;

    localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CNT - 1);
    localparam logic [16:0] POINTS_W = 17'(POINTS);
    localparam logic [16:0] PEN_W    = 17'(PENALTY);
    localparam logic [16:0] MAX_W    = 17'(MAX_SCORE);

    logic [2:0] btn_raw;
    logic [2:0] press;   // {clr, dec, inc} single-cycle events

    assign btn_raw = {btn_clr, btn_dec, btn_inc};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic        sync_meta;
        logic        sync_lvl;
        logic [31:0] cnt;
        logic [31:0] cnt_nxt;
        logic        deb_lvl;
        logic        deb_lvl_q;
        deb_state_t  state;
        deb_state_t  state_nxt;

        // NOTE: every flop here uses <= so all registers sample the pre-edge values of each other;
        // a blocking assignment would let sync_lvl see this cycle's sync_meta and drop a stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_meta <= 1'b0;
                sync_lvl  <= 1'b0;
                state     <= IDLE_LOW;
                cnt       <= '0;
                deb_lvl_q <= 1'b0;
            end else begin
                sync_meta <= btn_raw[i];
                sync_lvl  <= sync_meta;
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                deb_lvl_q <= deb_lvl;
            end
        end

        assign deb_lvl = (state == IDLE_HIGH) || (state == QUAL_LOW);

        // NOTE: defaults are assigned before any branch so every path drives every output;
        // a missing default in always_comb infers a latch.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = '0;
            if (sync_lvl == deb_lvl) begin
                state_nxt = deb_lvl ? IDLE_HIGH : IDLE_LOW;
            end else if (cnt == CNT_LAST) begin
                state_nxt = sync_lvl ? IDLE_HIGH : IDLE_LOW;
            end else begin
                cnt_nxt   = cnt + 32'd1;
                state_nxt = sync_lvl ? QUAL_HIGH : QUAL_LOW;
            end
        end

        // Rising edge of the debounced level only; release and hold produce nothing.
        assign press[i] = deb_lvl & ~deb_lvl_q;
    end

    logic [16:0] score_w;
    logic [16:0] sum_inc;
    logic [15:0] score_nxt;

    assign score_w = {1'b0, score};
    assign sum_inc = score_w + POINTS_W;

    always_comb begin
        score_nxt = score;
        if (press[2]) begin
            score_nxt = '0;
        end else if (press[0] && press[1]) begin
            score_nxt = score;
        end else if (press[0]) begin
            score_nxt = (sum_inc > MAX_W) ? MAX_W[15:0] : sum_inc[15:0];
        end else if (press[1]) begin
            score_nxt = (score_w < PEN_W) ? 16'd0 : 16'(score_w - PEN_W);
        end
    end

    // high_score follows the registered score, so it lags a score update by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score         <= '0;
            high_score    <= '0;
            score_changed <= 1'b0;
        end else begin
            score         <= score_nxt;
            score_changed <= (score_nxt != score);
            if (score > high_score) begin
                high_score <= score;
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: two instances with different POINTS/PENALTY share the buttons,
// a reference model pushes expected scores and a monitor pops them on every score_changed pulse.
module tb_score_keeper;

    localparam int D     = 4;
    localparam int MAX   = 9999;
    localparam int PTS_S = 1;
    localparam int PEN_S = 5;
    localparam int PTS_B = 1000;
    localparam int PEN_B = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] score_s, high_s, score_b, high_b;
    logic        chg_s, chg_b;

    int passed = 0;
    int total  = 0;
    int q_s[$];
    int q_b[$];
    int m_score_s = 0, m_high_s = 0, m_score_b = 0, m_high_b = 0;

    always #5 clk = ~clk;

    score_keeper #(.DEBOUNCE_CNT(D), .POINTS(PTS_S), .PENALTY(PEN_S), .MAX_SCORE(MAX)) u_s (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .score(score_s), .high_score(high_s), .score_changed(chg_s)
    );

    score_keeper #(.DEBOUNCE_CNT(D), .POINTS(PTS_B), .PENALTY(PEN_B), .MAX_SCORE(MAX)) u_b (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .score(score_b), .high_score(high_b), .score_changed(chg_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int next_score(input int s, input bit inc, input bit dec, input bit clr,
                                      input int pts, input int pen);
        if (clr) return 0;
        if (inc && dec) return s;
        if (inc) return (s + pts > MAX) ? MAX : s + pts;
        if (dec) return (s < pen) ? 0 : s - pen;
        return s;
    endfunction

    task automatic model_press(input bit inc, input bit dec, input bit clr);
        int n;
        n = next_score(m_score_s, inc, dec, clr, PTS_S, PEN_S);
        if (n != m_score_s) q_s.push_back(n);
        m_score_s = n;
        if (n > m_high_s) m_high_s = n;
        n = next_score(m_score_b, inc, dec, clr, PTS_B, PEN_B);
        if (n != m_score_b) q_b.push_back(n);
        m_score_b = n;
        if (n > m_high_b) m_high_b = n;
    endtask

    // Monitor: every change pulse must match the oldest outstanding expected score.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chg_s) begin
                if (q_s.size() == 0) check("u_s pulse with empty queue", q_s.size(), 1);
                else check("u_s score at pulse", int'(score_s), q_s.pop_front());
            end
            if (chg_b) begin
                if (q_b.size() == 0) check("u_b pulse with empty queue", q_b.size(), 1);
                else check("u_b score at pulse", int'(score_b), q_b.pop_front());
            end
        end
    end

    task automatic check_state(input string tag);
        check({tag, " u_s score"}, int'(score_s), m_score_s);
        check({tag, " u_s high"}, int'(high_s), m_high_s);
        check({tag, " u_b score"}, int'(score_b), m_score_b);
        check({tag, " u_b high"}, int'(high_b), m_high_b);
        check({tag, " u_s changed idle"}, int'(chg_s), 0);
        check({tag, " u_b changed idle"}, int'(chg_b), 0);
        check({tag, " u_s queue drained"}, q_s.size(), 0);
        check({tag, " u_b queue drained"}, q_b.size(), 0);
    endtask

    // A press held for fewer than D clocks is a glitch and must produce no event.
    task automatic op(input bit inc, input bit dec, input bit clr, input int hold, input string tag);
        @(posedge clk);
        #1;
        if (hold >= D) model_press(inc, dec, clr);
        btn_inc = inc;
        btn_dec = dec;
        btn_clr = clr;
        repeat (hold) @(posedge clk);
        #1;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_clr = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        #2;
        check("reset u_s score", int'(score_s), 0);
        check("reset u_s high", int'(high_s), 0);
        check("reset u_s changed", int'(chg_s), 0);
        check("reset u_b score", int'(score_b), 0);
        check("reset u_b high", int'(high_b), 0);
        check("reset u_b changed", int'(chg_b), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3; i++) op(1, 0, 0, 20, "clean inc");
        op(1, 0, 0, 2, "glitch 2");
        op(1, 0, 0, 3, "glitch 3");
        op(1, 0, 0, D, "inc min hold");
        op(0, 1, 0, 20, "dec below penalty");
        op(0, 1, 0, 20, "dec at zero");
        for (int i = 0; i < 8; i++) op(1, 0, 0, 12, "inc to saturate");
        op(1, 0, 0, 12, "inc at max");
        op(0, 0, 1, 20, "clear");
        op(1, 0, 0, 12, "inc after clear");
        op(1, 0, 0, 12, "inc after clear");
        op(0, 0, 1, 12, "clear nonzero");
        op(0, 0, 1, 12, "clear at zero");
        op(1, 0, 0, 12, "inc before pair");
        op(1, 1, 0, 12, "inc and dec together");
        op(1, 1, 1, 12, "clear wins");
        for (int i = 0; i < 11; i++) op(1, 0, 0, 8, "inc to max again");

        for (int i = 0; i < 30; i++) begin
            int sel;
            int hold;
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(D, 20);
            case (sel)
                0, 1, 2, 3: op(1, 0, 0, hold, "rand inc");
                4, 5:       op(0, 1, 0, hold, "rand dec");
                6:          op(0, 0, 1, hold, "rand clr");
                7:          op(1, 1, 0, hold, "rand inc+dec");
                default:    op(sel[0], ~sel[0], 1'b0, $urandom_range(1, D - 1), "rand glitch");
            endcase
        end

        // Reset while btn_inc is mid-qualification, then re-qualification after release of reset.
        op(1, 0, 0, 10, "inc before reset");
        @(posedge clk);
        #1 btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        q_s.delete();
        q_b.delete();
        m_score_s = 0; m_high_s = 0; m_score_b = 0; m_high_b = 0;
        check("async reset u_s score", int'(score_s), 0);
        check("async reset u_s high", int'(high_s), 0);
        check("async reset u_s changed", int'(chg_s), 0);
        check("async reset u_b score", int'(score_b), 0);
        check("async reset u_b high", int'(high_b), 0);
        check("async reset u_b changed", int'(chg_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_press(1, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("requalify early u_s score", int'(score_s), 0);
        check("requalify early u_b score", int'(score_b), 0);
        repeat (5) @(posedge clk);
        #1;
        check("requalify done u_s score", int'(score_s), m_score_s);
        check("requalify done u_b score", int'(score_b), m_score_b);
        btn_inc = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_state("after reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
